// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: per-channel 2-flop synchronizers, debounce
// filters, Gray-step decoding with a signed detent accumulator, and
// registered one-cycle plus/minus/err pulses.
module quad_decoder #(
  parameter int DEBOUNCE = 4,
  parameter int STEPS    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  output logic plus,
  output logic minus,
  output logic dir,
  output logic err
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic signed [3:0] ACC_MAX = 4'(STEPS - 1);
  localparam logic signed [3:0] ACC_MIN = -ACC_MAX;
  localparam logic signed [3:0] ACC_ZERO = 4'sd0;
  localparam logic signed [3:0] ACC_ONE = 4'sd1;
  // Edges after reset release during which filters may still be catching up
  // with the physical encoder position; the decoder only tracks the state.
  localparam logic [8:0] SETTLE_LAST = 9'(DEBOUNCE + 2);

  localparam logic [1:0] STEP_NONE = 2'd0;
  localparam logic [1:0] STEP_FWD  = 2'd1;
  localparam logic [1:0] STEP_BWD  = 2'd2;
  localparam logic [1:0] STEP_ILL  = 2'd3;

  logic a_meta_r, a_sync_r, b_meta_r, b_sync_r;
  logic fa_r, fb_r;
  logic [CW-1:0] cnt_a_r, cnt_b_r;
  logic [CW:0] filt_a_s, filt_b_s;
  logic pa_r, pb_r;
  logic armed_r;
  logic [8:0] settle_cnt_r;
  logic signed [3:0] acc_r, acc_s;
  logic plus_r, minus_r, dir_r, err_r;
  logic plus_s, minus_s, dir_s, err_s;
  logic [1:0] step_s;

  // Debounce update: returns {new_level, new_count}.
  function automatic logic [CW:0] filter_next(input logic sync_v,
                                              input logic level_v,
                                              input logic [CW-1:0] cnt_v);
    logic [CW:0] res;
    if (sync_v == level_v) begin
      res = {level_v, CNT_ZERO};
    end else if (cnt_v == DB_LAST) begin
      res = {sync_v, CNT_ZERO};
    end else begin
      res = {level_v, cnt_v + CNT_ONE};
    end
    return res;
  endfunction

  assign filt_a_s = filter_next(a_sync_r, fa_r, cnt_a_r);
  assign filt_b_s = filter_next(b_sync_r, fb_r, cnt_b_r);

  // Two-flop synchronizers for the asynchronous encoder channels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_meta_r <= 1'b0;
      a_sync_r <= 1'b0;
      b_meta_r <= 1'b0;
      b_sync_r <= 1'b0;
    end else begin
      a_meta_r <= a;
      a_sync_r <= a_meta_r;
      b_meta_r <= b;
      b_sync_r <= b_meta_r;
    end
  end

  // Debounce filters: level follows sync only after DEBOUNCE stable samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fa_r    <= 1'b0;
      cnt_a_r <= CNT_ZERO;
      fb_r    <= 1'b0;
      cnt_b_r <= CNT_ZERO;
    end else begin
      fa_r    <= filt_a_s[CW];
      cnt_a_r <= filt_a_s[CW-1:0];
      fb_r    <= filt_b_s[CW];
      cnt_b_r <= filt_b_s[CW-1:0];
    end
  end

  // Post-reset settling window so a non-00 power-up position is absorbed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_r      <= 1'b0;
      settle_cnt_r <= 9'd0;
    end else if (!armed_r) begin
      if (settle_cnt_r == SETTLE_LAST) begin
        armed_r <= 1'b1;
      end else begin
        settle_cnt_r <= settle_cnt_r + 9'd1;
      end
    end else begin
      armed_r <= 1'b1;
    end
  end

  // Classify the transition from the previous to the current filtered state.
  always_comb begin
    step_s = STEP_NONE;
    case ({pa_r, pb_r, fa_r, fb_r})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: step_s = STEP_FWD;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: step_s = STEP_BWD;
      4'b0011, 4'b0110, 4'b1001, 4'b1100: step_s = STEP_ILL;
      default:                            step_s = STEP_NONE;
    endcase
  end

  // Accumulator, direction and pulse next-state.
  always_comb begin
    acc_s   = acc_r;
    dir_s   = dir_r;
    plus_s  = 1'b0;
    minus_s = 1'b0;
    err_s   = 1'b0;
    if (!armed_r) begin
      acc_s = ACC_ZERO;
    end else begin
      case (step_s)
        STEP_FWD: begin
          dir_s = 1'b1;
          if (acc_r == ACC_MAX) begin
            acc_s  = ACC_ZERO;
            plus_s = 1'b1;
          end else begin
            acc_s = acc_r + ACC_ONE;
          end
        end
        STEP_BWD: begin
          dir_s = 1'b0;
          if (acc_r == ACC_MIN) begin
            acc_s   = ACC_ZERO;
            minus_s = 1'b1;
          end else begin
            acc_s = acc_r - ACC_ONE;
          end
        end
        STEP_ILL: begin
          acc_s = ACC_ZERO;
          err_s = 1'b1;
        end
        default: begin
          acc_s = acc_r;
        end
      endcase
    end
  end

  // Decoder state: previous position always reloads so errors resynchronize.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pa_r    <= 1'b0;
      pb_r    <= 1'b0;
      acc_r   <= ACC_ZERO;
      plus_r  <= 1'b0;
      minus_r <= 1'b0;
      dir_r   <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      pa_r    <= fa_r;
      pb_r    <= fb_r;
      acc_r   <= acc_s;
      plus_r  <= plus_s;
      minus_r <= minus_s;
      dir_r   <= dir_s;
      err_r   <= err_s;
    end
  end

  assign plus  = plus_r;
  assign minus = minus_r;
  assign dir   = dir_r;
  assign err   = err_r;

endmodule

// File: tb/tb_quad_decoder.sv
// Scoreboard bench for quad_decoder: stimulus queues expected pulses,
// a negedge monitor pops and compares whenever plus/minus/err is raised.
module tb_quad_decoder;

  localparam int DEBOUNCE = 4;
  localparam int STEPS    = 4;
  // Edges from the input change (driven mid-cycle) to the visible pulse.
  localparam int LAT = DEBOUNCE + 3;

  localparam logic [2:0] K_NONE  = 3'b000;
  localparam logic [2:0] K_PLUS  = 3'b001;
  localparam logic [2:0] K_MINUS = 3'b010;
  localparam logic [2:0] K_ERR   = 3'b100;

  logic clk;
  logic rst_n;
  logic a;
  logic b;
  logic plus;
  logic minus;
  logic dir;
  logic err;

  typedef struct {
    logic [2:0] kind;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  quad_decoder #(.DEBOUNCE(DEBOUNCE), .STEPS(STEPS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .plus  (plus),
    .minus (minus),
    .dir   (dir),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to timestamp expected and observed pulses.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every raised output must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t       e;
    logic [2:0] act;
    act = {err, minus, plus};
    if (rst_n === 1'b1 && act != K_NONE) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: got {err,minus,plus}=%b at cycle %0d, expected none",
                 act, cyc);
      end else begin
        e = sb_q.pop_front();
        if (act !== e.kind || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL pulse: got {err,minus,plus}=%b at cycle %0d, expected %b at cycle %0d",
                   act, cyc, e.kind, e.cyc);
        end
      end
    end
  end

  task automatic check_bit(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Drive a new {a,b} position mid-cycle and hold it for 'hold' cycles.
  task automatic drive(input logic na, input logic nb, input logic [2:0] ek, input int hold);
    @(negedge clk);
    #1;
    a = na;
    b = nb;
    if (ek != K_NONE) sb_q.push_back('{ek, cyc + LAT});
    repeat (hold - 1) @(negedge clk);
  endtask

  // Assert reset away from a clock edge and check outputs clear at once.
  task automatic do_reset(input logic na, input logic nb, input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    a = na;
    b = nb;
    #1;
    check_bit({tag, "_plus"},  plus,  1'b0);
    check_bit({tag, "_minus"}, minus, 1'b0);
    check_bit({tag, "_dir"},   dir,   1'b0);
    check_bit({tag, "_err"},   err,   1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    a = 1'b0;
    b = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check_bit("por_plus",  plus,  1'b0);
    check_bit("por_minus", minus, 1'b0);
    check_bit("por_dir",   dir,   1'b0);
    check_bit("por_err",   err,   1'b0);
    do_reset(1'b0, 1'b0, "rst0");
    repeat (20) @(negedge clk);

    // Full forward detent: one plus, dir forward.
    drive(1'b0, 1'b1, K_NONE, 10);
    drive(1'b1, 1'b1, K_NONE, 10);
    drive(1'b1, 1'b0, K_NONE, 10);
    drive(1'b0, 1'b0, K_PLUS, 10);
    check_bit("fwd_dir", dir, 1'b1);
    check_int("fwd_pending", sb_q.size(), 0);

    // Full backward detent: one minus, dir backward.
    drive(1'b1, 1'b0, K_NONE, 10);
    drive(1'b1, 1'b1, K_NONE, 10);
    drive(1'b0, 1'b1, K_NONE, 10);
    drive(1'b0, 1'b0, K_MINUS, 10);
    check_bit("bwd_dir", dir, 1'b0);
    check_int("bwd_pending", sb_q.size(), 0);

    // Three-cycle glitch on a is filtered out completely.
    drive(1'b1, 1'b0, K_NONE, 3);
    drive(1'b0, 1'b0, K_NONE, 20);
    check_bit("glitch_dir", dir, 1'b0);
    check_int("glitch_pending", sb_q.size(), 0);

    // Both channels change together: err, and again on the way back.
    drive(1'b1, 1'b1, K_ERR, 12);
    drive(1'b0, 1'b0, K_ERR, 12);
    check_bit("ill_dir", dir, 1'b0);
    check_int("ill_pending", sb_q.size(), 0);

    // Reversal mid-detent: +2 then -2 returns to zero without a pulse.
    drive(1'b0, 1'b1, K_NONE, 10);
    drive(1'b1, 1'b1, K_NONE, 10);
    check_bit("rev_dir_fwd", dir, 1'b1);
    drive(1'b0, 1'b1, K_NONE, 10);
    drive(1'b0, 1'b0, K_NONE, 10);
    // Two more backward steps leave acc at -2: still no pulse.
    drive(1'b1, 1'b0, K_NONE, 10);
    drive(1'b1, 1'b1, K_NONE, 10);
    check_bit("rev_dir_bwd", dir, 1'b0);
    check_int("rev_pending", sb_q.size(), 0);
    // Reaching -3 and one step past it emits the minus pulse.
    drive(1'b0, 1'b1, K_NONE, 10);
    drive(1'b0, 1'b0, K_MINUS, 10);
    check_int("rev_minus_pending", sb_q.size(), 0);

    // Power-up with encoder at 11: no pulse and no err.
    do_reset(1'b1, 1'b1, "rst11");
    repeat (30) @(negedge clk);
    check_int("pwr11_pending", sb_q.size(), 0);
    drive(1'b0, 1'b1, K_NONE, 10);
    drive(1'b0, 1'b0, K_NONE, 10);
    do_reset(1'b0, 1'b0, "rst00");
    repeat (20) @(negedge clk);

    // Reset after three forward steps discards progress.
    drive(1'b0, 1'b1, K_NONE, 10);
    drive(1'b1, 1'b1, K_NONE, 10);
    drive(1'b1, 1'b0, K_NONE, 10);
    check_bit("mid_dir_before", dir, 1'b1);
    do_reset(1'b1, 1'b0, "rst_mid");
    repeat (40) @(negedge clk);
    // A further forward step starts a fresh detent: no pulse.
    drive(1'b0, 1'b0, K_NONE, 20);
    check_bit("mid_dir_after", dir, 1'b1);
    check_int("final_pending", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
